// File: rtl/mac_accum.sv
// mac_accum: final carry-propagate add and dot-product accumulator for the 8x8 MAC.
//
// Stage 1 resolves the reducer's two carry-save rows into one ROW_W+1 bit product.
// Stage 2 adds that product into the running group sum. When the product is
// flagged last, the finished sum, sticky overflow and product count are moved
// into the output register and the accumulator restarts from zero.
// A pending result that downstream has not taken stalls the whole pipeline, so
// nothing is dropped and the output fields stay stable until they are taken.
module mac_accum #(
    parameter int unsigned ROW_W = 16,
    parameter int unsigned ACC_W = 24,  // must be >= ROW_W + 1
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // Carry-save product input
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [ROW_W-1:0] row1_i,
    input  logic [ROW_W-1:0] row2_i,
    input  logic             in_last_i,
    // Finished group output
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] acc_out_o,
    output logic             out_ovf_o,
    output logic [CNT_W-1:0] out_count_o
);

    localparam int unsigned SumW = ROW_W + 1;

    // Stage 1: resolved product
    logic            p_valid_q, p_valid_d;
    logic            p_last_q,  p_last_d;
    logic [SumW-1:0] p_sum_q,   p_sum_d;

    // Stage 2: running group state
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Output register
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] acc_out_q,   acc_out_d;
    logic             out_ovf_q,   out_ovf_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    // Shared datapath terms
    logic             stall;
    logic [ACC_W:0]   acc_sum;   // one extra bit captures the carry out of ACC_W
    logic             acc_carry;
    logic [CNT_W-1:0] cnt_inc;   // saturating count including the incoming product

    // A held result that downstream refuses freezes every stage.
    assign stall      = out_valid_q & ~out_ready_i;
    assign in_ready_o = ~stall;

    assign acc_sum   = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(p_sum_q);
    assign acc_carry = acc_sum[ACC_W];
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Stage 1 next state: full-width add of the two carry-save rows.
    always_comb begin
        p_valid_d = p_valid_q;
        p_last_d  = p_last_q;
        p_sum_d   = p_sum_q;
        if (!stall) begin
            p_valid_d = in_valid_i;
            p_last_d  = in_last_i;
            p_sum_d   = SumW'(row1_i) + SumW'(row2_i);
        end
    end

    // Stage 2 and output register next state: accumulate, or close the group.
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        acc_out_d   = acc_out_q;
        out_ovf_d   = out_ovf_q;
        out_count_d = out_count_q;
        if (!stall) begin
            // Pop first; a group closing on the same edge overrides it (no bubble).
            if (out_valid_q && out_ready_i) begin
                out_valid_d = 1'b0;
            end
            if (p_valid_q) begin
                if (p_last_q) begin
                    acc_out_d   = acc_sum[ACC_W-1:0];
                    out_ovf_d   = ovf_q | acc_carry;
                    out_count_d = cnt_inc;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    cnt_d       = '0;
                end else begin
                    acc_d = acc_sum[ACC_W-1:0];
                    ovf_d = ovf_q | acc_carry;
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_sum_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            p_sum_q     <= p_sum_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            out_ovf_q   <= out_ovf_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign acc_out_o   = acc_out_q;
    assign out_ovf_o   = out_ovf_q;
    assign out_count_o = out_count_q;

endmodule
